// File: rtl/isa_cycle_engine.sv
// isa_cycle_engine
// Runs one ISA bus cycle (8/16-bit, I/O or memory, read or write) per
// accepted start pulse: ALE -> SETUP -> STROBE -> HOLD -> DONE.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   start               one-cycle command request, only honoured in IDLE
//   address_in/data_in  command address and write data
//   control_in          [0] write, [1] memory, [2] 16-bit; [7:3] ignored
//   isa_sd_in           ISA data bus input (read data)
//   isa_iochrdy         ISA ready, low extends the strobe
//   isa_sa, isa_sd_out, isa_sd_oe, isa_bale, isa_*_n   ISA bus drive
//   busy, done, rd_data, timeout                        host-side status
//
// state  | meaning
// IDLE   | waiting for start, bus strobes inactive
// ALE    | BALE high for one cycle, address driven
// SETUP  | BALE low, address settling before the strobe
// STROBE | one strobe low, minimum width then IOCHRDY/timeout exit
// HOLD   | strobe released, address/write data still held
// DONE   | one-cycle completion pulse

module isa_cycle_engine #(
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 8,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] address_in,
  input  logic [15:0] data_in,
  input  logic [7:0]  control_in,
  input  logic [15:0] isa_sd_in,
  input  logic        isa_iochrdy,
  output logic [15:0] isa_sa,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  output logic        isa_bale,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic        isa_memr_n,
  output logic        isa_memw_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        timeout
);

  localparam int STRB_MAX = STROBE_CYCLES + TIMEOUT_CYCLES;
  localparam int CNT_MAX  = (STRB_MAX > SETUP_CYCLES) ?
                            ((STRB_MAX > HOLD_CYCLES) ? STRB_MAX : HOLD_CYCLES) :
                            ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ALE, ST_SETUP, ST_STROBE, ST_HOLD, ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] sa_q, sa_d;
  logic [15:0] sd_out_q, sd_out_d;
  logic        oe_q, oe_d;
  logic        bale_q, bale_d;
  logic        ior_n_q, ior_n_d;
  logic        iow_n_q, iow_n_d;
  logic        memr_n_q, memr_n_d;
  logic        memw_n_q, memw_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        timeout_q, timeout_d;
  logic        strobe_exit;
  logic        strobe_on;

  logic ctrl_unused;
  assign ctrl_unused = ^control_in[7:3];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    sa_d        = sa_q;
    sd_out_d    = sd_out_q;
    rd_data_d   = rd_data_q;
    timeout_d   = timeout_q;
    // Down-counter holds the cycles left in the strobe: at or below
    // TIMEOUT_CYCLES the minimum width is met, zero is the timeout limit.
    strobe_exit = ((cnt_q <= CW'(TIMEOUT_CYCLES)) && isa_iochrdy) ||
                  (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ALE;
          ctrl_d    = control_in[2:0];
          sa_d      = address_in;
          timeout_d = 1'b0;
          if (control_in[0]) begin
            // 8-bit writes mirror the byte onto both lanes.
            sd_out_d = control_in[2] ? data_in : {data_in[7:0], data_in[7:0]};
          end
        end
      end
      ST_ALE: begin
        state_d = ST_SETUP;
        cnt_d   = CW'(SETUP_CYCLES - 1);
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(STRB_MAX - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (strobe_exit) begin
          state_d   = ST_HOLD;
          cnt_d     = CW'(HOLD_CYCLES - 1);
          timeout_d = ~isa_iochrdy;
          if (!ctrl_q[0]) begin
            rd_data_d = ctrl_q[2] ? isa_sd_in : {8'h00, isa_sd_in[7:0]};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus outputs are decoded from the next state so they register in
    // step with the state they belong to.
    strobe_on = (state_d == ST_STROBE);
    bale_d    = (state_d == ST_ALE);
    oe_d      = ctrl_d[0] && ((state_d == ST_ALE) || (state_d == ST_SETUP) ||
                              (state_d == ST_STROBE) || (state_d == ST_HOLD));
    ior_n_d   = ~(strobe_on && (ctrl_d[1:0] == 2'b00));
    iow_n_d   = ~(strobe_on && (ctrl_d[1:0] == 2'b01));
    memr_n_d  = ~(strobe_on && (ctrl_d[1:0] == 2'b10));
    memw_n_d  = ~(strobe_on && (ctrl_d[1:0] == 2'b11));
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      sa_q      <= '0;
      sd_out_q  <= '0;
      oe_q      <= 1'b0;
      bale_q    <= 1'b0;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
      memr_n_q  <= 1'b1;
      memw_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      sa_q      <= sa_d;
      sd_out_q  <= sd_out_d;
      oe_q      <= oe_d;
      bale_q    <= bale_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
      memr_n_q  <= memr_n_d;
      memw_n_q  <= memw_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      timeout_q <= timeout_d;
    end
  end

  assign isa_sa     = sa_q;
  assign isa_sd_out = sd_out_q;
  assign isa_sd_oe  = oe_q;
  assign isa_bale   = bale_q;
  assign isa_ior_n  = ior_n_q;
  assign isa_iow_n  = iow_n_q;
  assign isa_memr_n = memr_n_q;
  assign isa_memw_n = memw_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_isa_cycle_engine.sv
module tb_isa_cycle_engine;

  localparam int SC = 2;
  localparam int STC = 8;
  localparam int HC = 2;
  localparam int TOC = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] address_in = '0;
  logic [15:0] data_in = '0;
  logic [7:0]  control_in = '0;
  logic [15:0] isa_sd_in = '0;
  logic        isa_iochrdy = 1'b1;
  logic [15:0] isa_sa, isa_sd_out, rd_data;
  logic        isa_sd_oe, isa_bale, isa_ior_n, isa_iow_n, isa_memr_n, isa_memw_n;
  logic        busy, done, timeout;

  isa_cycle_engine #(
    .SETUP_CYCLES(SC), .STROBE_CYCLES(STC), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .address_in(address_in), .data_in(data_in), .control_in(control_in),
    .isa_sd_in(isa_sd_in), .isa_iochrdy(isa_iochrdy),
    .isa_sa(isa_sa), .isa_sd_out(isa_sd_out), .isa_sd_oe(isa_sd_oe),
    .isa_bale(isa_bale), .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
    .isa_memr_n(isa_memr_n), .isa_memw_n(isa_memw_n),
    .busy(busy), .done(done), .rd_data(rd_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes_low();
    return ~{isa_memw_n, isa_memr_n, isa_iow_n, isa_ior_n};
  endfunction

  function automatic int other_low(input logic [1:0] sel);
    logic [3:0] lo;
    lo = strobes_low();
    lo[sel] = 1'b0;
    return $countones(lo);
  endfunction

  // ext: 0 = ready throughout, >0 = ready stays low that many cycles past
  // the minimum width, <0 = ready never returns.
  task automatic do_cycle(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] c, input logic [15:0] sdin, input int ext,
                          input bit poke, input int exp_str, input logic [15:0] exp_rd,
                          input logic exp_tmo);
    int busy_c = 0, bale_c = 0, str_c = 0, wrong_c = 0, oe_c = 0;
    int done_c = 0, done_at = 0, sa_bad = 0, sd_bad = 0, idle_busy = 0;
    bit poking = 0;
    int exp_busy;
    logic [15:0] exp_sd;
    logic [3:0] lo;
    exp_busy = 1 + SC + exp_str + HC + 1;
    exp_sd = c[2] ? d : {d[7:0], d[7:0]};

    @(negedge clk);
    address_in = a; data_in = d; control_in = c;
    isa_iochrdy = (ext == 0);
    isa_sd_in = (ext == 0) ? sdin : 16'hDEAD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    address_in = ~a; data_in = ~d; control_in = ~c;
    check({tag, "/tmo_clr_at_start"}, {31'd0, timeout}, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      if (poking) begin start = 1'b0; poking = 0; end
      if (!busy) break;
      busy_c++;
      lo = strobes_low();
      if (isa_bale) bale_c++;
      if (lo[c[1:0]]) str_c++;
      wrong_c += other_low(c[1:0]);
      if (isa_sd_oe) begin
        oe_c++;
        if (isa_sd_out !== exp_sd) sd_bad++;
      end
      if (isa_sa !== a) sa_bad++;
      if (done) begin
        done_c++;
        done_at = busy_c;
        if (poke) begin start = 1'b1; poking = 1; end
      end
      if (ext > 0 && lo[c[1:0]] && str_c == STC + ext) begin
        isa_iochrdy = 1'b1;
        isa_sd_in = sdin;
      end
      if (poke && lo[c[1:0]] && str_c == 3) begin start = 1'b1; poking = 1; end
      @(negedge clk);
    end
    start = 1'b0;

    check({tag, "/busy_cycles"}, busy_c, exp_busy);
    check({tag, "/bale_cycles"}, bale_c, 1);
    check({tag, "/strobe_cycles"}, str_c, exp_str);
    check({tag, "/wrong_strobe"}, wrong_c, 0);
    check({tag, "/oe_cycles"}, oe_c, c[0] ? exp_busy - 1 : 0);
    check({tag, "/sd_out_bad"}, sd_bad, 0);
    check({tag, "/sa_bad"}, sa_bad, 0);
    check({tag, "/done_pulses"}, done_c, 1);
    check({tag, "/done_at"}, done_at, exp_busy);
    check({tag, "/rd_data"}, rd_data, exp_rd);
    check({tag, "/timeout"}, {31'd0, timeout}, {31'd0, exp_tmo});
    check({tag, "/sa_idle"}, isa_sa, a);
    if (poke) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy || done) idle_busy++;
      end
      check({tag, "/no_queued_start"}, idle_busy, 0);
    end
    isa_iochrdy = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst/strobes", {28'd0, strobes_low()}, 32'd0);
    check("rst/bale_oe_busy_done", {28'd0, isa_bale, isa_sd_oe, busy, done}, 32'd0);
    check("rst/sa", isa_sa, 16'h0000);
    check("rst/sd_out", isa_sd_out, 16'h0000);
    check("rst/rd_tmo", {15'd0, timeout, rd_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_cycle("io_wr8", 16'h0220, 16'h00A5, 8'h01, 16'h0000, 0, 0, 8, 16'h0000, 1'b0);
    do_cycle("mem_rd16", 16'h8000, 16'h0000, 8'h06, 16'h1234, 0, 0, 8, 16'h1234, 1'b0);
    do_cycle("io_rd8_wait5", 16'h0300, 16'h0000, 8'h00, 16'h5678, 5, 0, 13, 16'h0078, 1'b0);
    do_cycle("io_wr16_tmo", 16'h0310, 16'hBEEF, 8'h05, 16'h0000, -1, 0, STC + TOC, 16'h0078, 1'b1);
    do_cycle("mem_wr8_poke", 16'h4000, 16'h1234, 8'h03, 16'h0000, 0, 1, 8, 16'h0078, 1'b0);
    do_cycle("mem_rd8", 16'h4002, 16'h0000, 8'h02, 16'hCD9A, 0, 0, 8, 16'h009A, 1'b0);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    address_in = 16'h0330; data_in = 16'h5A5A; control_in = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("rstmid/iow_low_before", {31'd0, isa_iow_n}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rstmid/iow_released", {31'd0, isa_iow_n}, 32'd1);
    check("rstmid/oe_released", {31'd0, isa_sd_oe}, 32'd0);
    check("rstmid/busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid/busy_after", {31'd0, busy}, 32'd0);
    check("rstmid/rd_data_after", rd_data, 16'h0000);
    check("rstmid/sa_after", isa_sa, 16'h0000);
    check("rstmid/strobes_after", {28'd0, strobes_low()}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
